// File: rtl/load_store_unit.sv
// Load/store unit: aligns EX-stage memory requests onto a word-wide data port,
// waits for mem_ack with a timeout, and returns right-aligned load data.
//
// state | meaning
// IDLE  | ready for a request; misaligned requests are rejected with err
// WAIT  | mem_req held with latched fields until mem_ack or timeout
// RESP  | one-cycle rsp_valid with captured load data
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [1:0]  whb,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_whb,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  whb_q, whb_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;

    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] lane_shifted;
    logic [31:0] load_data;

    assign misaligned  = (whb == 2'b11)
                       || ((whb == 2'b01) && addr[0])
                       || ((whb == 2'b10) && (addr[1:0] != 2'b00));
    assign accept      = (state_q == IDLE) && req_valid && !misaligned;
    assign timeout_hit = (wait_cnt_q == WAIT_LAST);

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (whb)
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << addr[1:0];
                wdata_calc = {2{wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata;
            end
        endcase
    end

    // Load lane extraction uses the latched size/offset, result is zero-extended.
    always_comb begin
        lane_shifted = mem_rdata >> {off_q, 3'b000};
        load_data    = mem_rdata;
        case (whb_q)
            2'b00:   load_data = {24'h000000, lane_shifted[7:0]};
            2'b01:   load_data = {16'h0000, (off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            whb_q      <= 2'b10;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            rdata_q    <= 32'h0;
            wait_cnt_q <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            whb_q      <= whb_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: begin
                if (mem_ack)          state_d = RESP;
                else if (timeout_hit) state_d = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        whb_d      = whb_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && misaligned) err_d = 1'b1;
                if (accept) begin
                    we_d       = is_store;
                    addr_d     = {addr[31:2], 2'b00};
                    be_d       = be_calc;
                    wdata_d    = wdata_calc;
                    whb_d      = whb;
                    uns_d      = ld_unsigned && !is_store;
                    off_d      = addr[1:0];
                    rdata_d    = 32'h0;
                    wait_cnt_d = 5'd0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        rsp_whb   = 2'b10;
        err       = err_q;
        case (state_q)
            IDLE: req_ready = 1'b1;
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_be    = be_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rdata_q;
                // Unsigned loads are already zero-extended, so present them as words.
                rsp_whb   = (we_q || uns_q) ? 2'b10 : whb_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario, inline checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [1:0]  whb;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_whb;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .whb(whb), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_whb(rsp_whb),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; is_store = 0; whb = 2'b00; ld_unsigned = 0;
        addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        step(); step();
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", req_ready); end
        vectors++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin miscompares++; $display("FAIL rst_mem got %b want 0", {mem_req, mem_we, mem_be}); end
        vectors++; if ({mem_addr, mem_wdata} !== 64'h0) begin miscompares++; $display("FAIL rst_bus got %h want 0", {mem_addr, mem_wdata}); end
        vectors++; if ({rsp_valid, err, rsp_data} !== 34'h0) begin miscompares++; $display("FAIL rst_rsp got %h want 0", {rsp_valid, err, rsp_data}); end
        vectors++; if (rsp_whb !== 2'b10) begin miscompares++; $display("FAIL rst_whb got %b want 10", rsp_whb); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_byte();
        req_valid = 1; is_store = 0; whb = 2'b00; ld_unsigned = 0; addr = 32'h0000_1003;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL lb_ready got %b want 1", req_ready); end
        step(); req_valid = 0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL lb_req got %b want 1", mem_req); end
        vectors++; if (mem_be !== 4'b1000) begin miscompares++; $display("FAIL lb_be got %b want 1000", mem_be); end
        vectors++; if (mem_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL lb_addr got %h want 00001000", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL lb_we got %b want 0", mem_we); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL lb_busy got %b want 0", req_ready); end
        step();
        vectors++; if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1000, 32'h0000_1000}) begin miscompares++; $display("FAIL lb_hold got %h want 18_00001000", {mem_req, mem_be, mem_addr}); end
        mem_ack = 1; mem_rdata = 32'h80FF_1234;
        step(); mem_ack = 0; mem_rdata = 0;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lb_rspv got %b want 1", rsp_valid); end
        vectors++; if (rsp_data !== 32'h0000_0080) begin miscompares++; $display("FAIL lb_data got %h want 00000080", rsp_data); end
        vectors++; if (rsp_whb !== 2'b00) begin miscompares++; $display("FAIL lb_whb got %b want 00", rsp_whb); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lb_reqdrop got %b want 0", mem_req); end
        step();
        vectors++; if ({rsp_valid, req_ready} !== 2'b01) begin miscompares++; $display("FAIL lb_end got %b want 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_load_half_unsigned();
        req_valid = 1; is_store = 0; whb = 2'b01; ld_unsigned = 1; addr = 32'h0000_2002;
        step(); req_valid = 0; ld_unsigned = 0;
        vectors++; if (mem_be !== 4'b1100) begin miscompares++; $display("FAIL lhu_be got %b want 1100", mem_be); end
        mem_ack = 1; mem_rdata = 32'hBEEF_0000;
        step(); mem_ack = 0; mem_rdata = 0;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lhu_rspv got %b want 1", rsp_valid); end
        vectors++; if (rsp_data !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lhu_data got %h want 0000beef", rsp_data); end
        vectors++; if (rsp_whb !== 2'b10) begin miscompares++; $display("FAIL lhu_whb got %b want 10", rsp_whb); end
        step();
    endtask

    // Signed half load; the EX stage changes req fields during WAIT and must be ignored.
    task automatic test_load_half_signed_busy();
        req_valid = 1; is_store = 0; whb = 2'b01; ld_unsigned = 0; addr = 32'h0000_7000;
        step();
        addr = 32'h0000_7001; whb = 2'b10;
        step();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL lh_busy_err got %b want 0", err); end
        vectors++; if ({mem_addr, mem_be} !== {32'h0000_7000, 4'b0011}) begin miscompares++; $display("FAIL lh_busy_hold got %h want 70003", {mem_addr, mem_be}); end
        mem_ack = 1; mem_rdata = 32'h1234_8765;
        step(); mem_ack = 0; mem_rdata = 0; req_valid = 0;
        vectors++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000_8765}) begin miscompares++; $display("FAIL lh_data got %h want 1_00008765", {rsp_valid, rsp_data}); end
        vectors++; if (rsp_whb !== 2'b01) begin miscompares++; $display("FAIL lh_whb got %b want 01", rsp_whb); end
        step();
        vectors++; if ({req_ready, mem_req, err} !== 3'b100) begin miscompares++; $display("FAIL lh_idle got %b want 100", {req_ready, mem_req, err}); end
    endtask

    task automatic test_store_half();
        req_valid = 1; is_store = 1; whb = 2'b01; addr = 32'h0000_3002; wdata = 32'h0000_ABCD;
        step(); req_valid = 0; is_store = 0; wdata = 0;
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sh_we got %b want 1", mem_we); end
        vectors++; if (mem_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got %b want 1100", mem_be); end
        vectors++; if (mem_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata got %h want abcdabcd", mem_wdata); end
        vectors++; if (mem_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL sh_addr got %h want 00003000", mem_addr); end
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        step(); mem_ack = 0; mem_rdata = 0;
        vectors++; if ({rsp_valid, rsp_data, rsp_whb} !== {1'b1, 32'h0, 2'b10}) begin miscompares++; $display("FAIL sh_rsp got %h want 1_00000000_2", {rsp_valid, rsp_data, rsp_whb}); end
        step();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL sh_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_store_byte();
        req_valid = 1; is_store = 1; whb = 2'b00; addr = 32'h0000_8001; wdata = 32'h1234_5677;
        step(); req_valid = 0; is_store = 0; wdata = 0;
        vectors++; if ({mem_be, mem_wdata} !== {4'b0010, 32'h7777_7777}) begin miscompares++; $display("FAIL sb_lane got %h want 2_77777777", {mem_be, mem_wdata}); end
        mem_ack = 1;
        step(); mem_ack = 0;
        step();
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs [3] = '{32'h0000_4001, 32'h0000_4003, 32'h0000_4000};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; is_store = 0; whb = sizes[i]; addr = addrs[i];
            step(); req_valid = 0;
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL mis_err[%0d] got %b want 1", i, err); end
            vectors++; if ({mem_req, req_ready} !== 2'b01) begin miscompares++; $display("FAIL mis_state[%0d] got %b want 01", i, {mem_req, req_ready}); end
            step();
            vectors++; if ({err, mem_req, rsp_valid} !== 3'b000) begin miscompares++; $display("FAIL mis_after[%0d] got %b want 000", i, {err, mem_req, rsp_valid}); end
        end
    endtask

    task automatic test_ack_idle_ignored();
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        step(); step();
        vectors++; if ({rsp_valid, mem_req, err, req_ready} !== 4'b0001) begin miscompares++; $display("FAIL ack_idle got %b want 0001", {rsp_valid, mem_req, err, req_ready}); end
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic test_timeout();
        int cnt = 0;
        logic saw_rsp = 1'b0;
        req_valid = 1; is_store = 0; whb = 2'b10; addr = 32'h0000_5000;
        step(); req_valid = 0;
        while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            if (rsp_valid === 1'b1 || err === 1'b1) saw_rsp = 1'b1;
            step();
        end
        vectors++; if (cnt !== 16) begin miscompares++; $display("FAIL to_cycles got %0d want 16", cnt); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", err); end
        vectors++; if ({req_ready, rsp_valid, saw_rsp} !== 3'b100) begin miscompares++; $display("FAIL to_idle got %b want 100", {req_ready, rsp_valid, saw_rsp}); end
        step();
        vectors++; if ({err, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL to_after got %b want 00", {err, rsp_valid}); end
    endtask

    task automatic test_ack_at_timeout();
        req_valid = 1; is_store = 0; whb = 2'b10; addr = 32'h0000_6000;
        step(); req_valid = 0;
        repeat (15) step();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL edge_req got %b want 1", mem_req); end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        step(); mem_ack = 0; mem_rdata = 0;
        vectors++; if ({rsp_valid, err} !== 2'b10) begin miscompares++; $display("FAIL edge_win got %b want 10", {rsp_valid, err}); end
        vectors++; if (rsp_data !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL edge_data got %h want cafef00d", rsp_data); end
        step();
        vectors++; if ({err, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL edge_after got %b want 00", {err, rsp_valid}); end
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1; is_store = 1; whb = 2'b10; addr = 32'h0000_9000; wdata = 32'h1111_2222;
        step(); req_valid = 0; is_store = 0;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rw_req got %b want 1", mem_req); end
        #2 rst = 1;
        #1;
        vectors++; if ({mem_req, mem_we, req_ready} !== 3'b001) begin miscompares++; $display("FAIL rw_async got %b want 001", {mem_req, mem_we, req_ready}); end
        step(); rst = 0;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if ({rsp_valid, err, mem_req} !== 3'b000) begin miscompares++; $display("FAIL rw_quiet[%0d] got %b want 000", i, {rsp_valid, err, mem_req}); end
        end
        mem_ack = 0; mem_rdata = 0;
        vectors++; if ({mem_be, mem_wdata, mem_addr, rsp_data} !== 100'h0) begin miscompares++; $display("FAIL rw_bus got %h want 0", {mem_be, mem_wdata, mem_addr, rsp_data}); end
        vectors++; if ({rsp_whb, req_ready} !== 3'b101) begin miscompares++; $display("FAIL rw_whb got %b want 101", {rsp_whb, req_ready}); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_unsigned();
        test_load_half_signed_busy();
        test_store_half();
        test_store_byte();
        test_misaligned();
        test_ack_idle_ignored();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
